instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-cache request interface; sits in the IF stage between the PC logic and the instruction cache.
- Holds the PC and issues one outstanding request at a time: req/addr out, instr_valid/instruction back.
- Buffers returned instructions and their PCs in a small FIFO toward decode.
- Handles branch/jump redirects, including discard of an in-flight response.

---
 rtl/instr_fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch initiator for the IF stage. Holds the PC and keeps at most
// one request outstanding toward the instruction cache. Returned instructions
// and their PCs are queued in a small FIFO toward decode. Branch/jump
// redirects flush the FIFO and restart fetching. A response that is still in
// flight when the redirect arrives is dropped.
//
// Parameters:
//   ADDR_SIZE   address / PC width
//   INST_SIZE   instruction width
//   RESET_PC    PC loaded on reset (bits [1:0] must be 0)
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports:
//   i_aclk, i_areset          clock, synchronous active-high reset
//   o_req, o_addr             cache request; o_addr stable while o_req=1
//   i_instr_valid,
//   i_instruction             cache response (one-cycle pulse)
//   i_redirect,
//   i_redirect_pc             restart fetch at i_redirect_pc (one-cycle pulse)
//   o_valid, o_instruction,
//   o_pc, i_ready             FIFO head toward decode (valid/ready)
//
// Optional build macro INSTR_FETCH_PERF_CNT_EN adds:
//   o_stall_cycles            cycles with o_req=1 and no response (saturating)
//   o_fetch_count             responses actually pushed (saturating)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned          ADDR_SIZE  = 32,
    parameter int unsigned          INST_SIZE  = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned          FIFO_DEPTH = 4
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    output logic                 o_req,
    output logic [ADDR_SIZE-1:0] o_addr,
    input  logic                 i_instr_valid,
    input  logic [INST_SIZE-1:0] i_instruction,
    input  logic                 i_redirect,
    input  logic [ADDR_SIZE-1:0] i_redirect_pc,
    output logic                 o_valid,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic [ADDR_SIZE-1:0] o_pc,
`ifdef INSTR_FETCH_PERF_CNT_EN
    output logic [31:0]          o_stall_cycles,
    output logic [31:0]          o_fetch_count,
`endif
    input  logic                 i_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   pc_q, pc_d;
    logic [ADDR_SIZE-1:0]   target_q, target_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [ADDR_SIZE-1:0]   fifo_pc_mem    [FIFO_DEPTH];
    logic [INST_SIZE-1:0]   fifo_instr_mem [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic [ADDR_SIZE-1:0]   redirect_pc_aligned;

    assign redirect_pc_aligned = i_redirect_pc & ~ADDR_SIZE'(3);

    // Only a response that is not being cancelled by a same-cycle redirect
    // is kept; responses seen in DRAIN belong to the abandoned stream.
    assign push = (state_q == FETCH) && i_instr_valid && !i_redirect;
    assign pop  = (count_q != '0) && i_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_mem[PTR_W'(i)]    <= '0;
                fifo_instr_mem[PTR_W'(i)] <= '0;
            end
        end else if (push) begin
            fifo_pc_mem[wr_ptr_q]    <= pc_q;
            fifo_instr_mem[wr_ptr_q] <= i_instruction;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next values: PC, redirect target, FIFO pointers
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        target_d = target_q;

        unique case (state_q)
            IDLE: begin
                if (i_redirect) pc_d = redirect_pc_aligned;
            end
            FETCH: begin
                if (i_instr_valid) begin
                    pc_d = i_redirect ? redirect_pc_aligned : pc_q + ADDR_SIZE'(4);
                end else if (i_redirect) begin
                    target_d = redirect_pc_aligned;
                end
            end
            DRAIN: begin
                // The pending response closes the old request; the most
                // recent redirect (possibly this cycle's) decides the new PC.
                if (i_instr_valid) begin
                    pc_d = i_redirect ? redirect_pc_aligned : target_q;
                end else if (i_redirect) begin
                    target_d = redirect_pc_aligned;
                end
            end
            default: ;
        endcase

        if (i_redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (count_q < DEPTH_C) state_d = FETCH;
            end
            FETCH: begin
                if (i_instr_valid && !i_redirect) begin
                    if (count_d >= DEPTH_C) state_d = IDLE;
                end else if (i_redirect && !i_instr_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_instr_valid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_req         = (state_q != IDLE);
        o_addr        = pc_q;
        o_valid       = (count_q != '0);
        o_instruction = fifo_instr_mem[rd_ptr_q];
        o_pc          = fifo_pc_mem[rd_ptr_q];
    end

`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] fetch_q, fetch_d;

    always_comb begin
        stall_d = stall_q;
        fetch_d = fetch_q;
        if ((state_q != IDLE) && !i_instr_valid && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (push && (fetch_q != '1)) fetch_d = fetch_q + 32'd1;
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            stall_q <= '0;
            fetch_q <= '0;
        end else begin
            stall_q <= stall_d;
            fetch_q <= fetch_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_fetch_count  = fetch_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          i_areset;
    logic          o_req;
    logic [AW-1:0] o_addr;
    logic          i_instr_valid;
    logic [IW-1:0] i_instruction;
    logic          i_redirect;
    logic [AW-1:0] i_redirect_pc;
    logic          o_valid;
    logic [IW-1:0] o_instruction;
    logic [AW-1:0] o_pc;
    logic          i_ready;
`ifdef INSTR_FETCH_PERF_CNT_EN
    logic [31:0]   o_stall_cycles;
    logic [31:0]   o_fetch_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_SIZE (AW),
        .INST_SIZE (IW),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_aclk        (clk),
        .i_areset      (i_areset),
        .o_req         (o_req),
        .o_addr        (o_addr),
        .i_instr_valid (i_instr_valid),
        .i_instruction (i_instruction),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
`ifdef INSTR_FETCH_PERF_CNT_EN
        .o_stall_cycles(o_stall_cycles),
        .o_fetch_count (o_fetch_count),
`endif
        .i_ready       (i_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    entry_t        q[$];
    bit            m_req;      // a request is (expected to be) on the bus
    bit            m_drain;    // the outstanding request belongs to a dead stream
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_target;
    logic [31:0]   m_stall;
    logic [31:0]   m_fetch;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_step();
        int unsigned   pre_size = q.size();
        logic [AW-1:0] rpc      = {i_redirect_pc[AW-1:2], 2'b00};
        if (i_areset) begin
            q.delete();
            m_req    = 1'b0;
            m_drain  = 1'b0;
            m_pc     = RST_PC;
            m_target = RST_PC;
            m_stall  = 32'd0;
            m_fetch  = 32'd0;
            return;
        end
        if (m_req && !i_instr_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (i_ready && q.size() > 0) void'(q.pop_front());
        if (i_redirect) q.delete();
        if (!m_req) begin
            if (i_redirect) m_pc = rpc;
            m_req = (pre_size < DEPTH);
        end else if (m_drain) begin
            if (i_instr_valid) begin
                m_pc    = i_redirect ? rpc : m_target;
                m_drain = 1'b0;
            end else if (i_redirect) begin
                m_target = rpc;
            end
        end else begin
            if (i_instr_valid && !i_redirect) begin
                q.push_back({m_pc, i_instruction});
                m_pc = m_pc + 32'd4;
                if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
                m_req = (q.size() < DEPTH);
            end else if (i_instr_valid) begin
                m_pc = rpc;
            end else if (i_redirect) begin
                m_drain  = 1'b1;
                m_target = rpc;
            end
        end
    endtask

    task automatic compare();
        chk("o_req", o_req, m_req);
        chk("o_addr", o_addr, m_pc);
        chk("o_valid", o_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("o_pc", o_pc, q[0].pc);
            chk("o_instruction", o_instruction, q[0].instr);
        end
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("o_stall_cycles", o_stall_cycles, m_stall);
        chk("o_fetch_count", o_fetch_count, m_fetch);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] ins, input logic r,
                         input logic [AW-1:0] rpc, input logic rdy);
        i_instr_valid = v;
        i_instruction = ins;
        i_redirect    = r;
        i_redirect_pc = rpc;
        i_ready       = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        i_areset = 1'b1;
        step();
        i_areset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_areset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        step();
        chk("rst_o_req", o_req, 1'b0);
        chk("rst_o_addr", o_addr, 32'h0);
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_instruction", o_instruction, 32'h0);
        chk("rst_o_pc", o_pc, 32'h0);
        i_areset = 1'b0;

        // Sequential fetch, one response per cycle, decode always ready.
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        chk("seq_first_req", o_req, 1'b1);
        chk("seq_first_addr", o_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hA000_0000 + k, 1'b0, '0, 1'b1);
            step();
            chk("seq_addr", o_addr, 32'(4 * (k + 1)));
            chk("seq_valid", o_valid, 1'b1);
            chk("seq_pc", o_pc, 32'(4 * k));
        end

        // FIFO fills with decode stalled; one pop lets fetching resume at 0x10.
        do_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hB000_0000 + k, 1'b0, '0, 1'b0);
            step();
        end
        chk("full_req_drop", o_req, 1'b0);
        chk("full_head_pc", o_pc, 32'h0);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk("full_idle", o_req, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        chk("full_pop_pc", o_pc, 32'h4);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        step();
        chk("full_resume_req", o_req, 1'b1);
        chk("full_resume_addr", o_addr, 32'h10);

        // Redirect while the request to 0x8 is outstanding; response 3 cycles later.
        do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        drive(1'b1, 32'hC000_0000, 1'b0, '0, 1'b1);
        step();
        drive(1'b1, 32'hC000_0004, 1'b0, '0, 1'b1);
        step();
        chk("drain_pre_addr", o_addr, 32'h8);
        drive(1'b0, '0, 1'b1, 32'h103, 1'b1);
        step();
        chk("drain_flush", o_valid, 1'b0);
        chk("drain_addr_held", o_addr, 32'h8);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        step();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b1);
        step();
        chk("drain_new_addr", o_addr, 32'h100);
        chk("drain_discarded", o_valid, 1'b0);
        drive(1'b1, 32'hC000_0100, 1'b0, '0, 1'b1);
        step();
        chk("drain_new_pc", o_pc, 32'h100);

        // Redirect coincident with the response for 0x4.
        do_reset();
        step();
        drive(1'b1, 32'hD000_0000, 1'b0, '0, 1'b0);
        step();
        drive(1'b1, 32'hD000_0004, 1'b1, 32'h200, 1'b0);
        step();
        chk("coinc_flush", o_valid, 1'b0);
        chk("coinc_req", o_req, 1'b1);
        chk("coinc_addr", o_addr, 32'h200);

        // Two redirects during DRAIN: the last one wins.
        drive(1'b1, 32'hE000_0200, 1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b1, 32'h300, 1'b1);
        step();
        drive(1'b0, '0, 1'b1, 32'h400, 1'b1);
        step();
        chk("two_redir_held", o_addr, 32'h204);
        drive(1'b1, 32'hE000_0204, 1'b0, '0, 1'b1);
        step();
        chk("two_redir_addr", o_addr, 32'h400);

        // PC wrap at the top of the address space.
        drive(1'b1, 32'hF000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step();
        chk("wrap_pre_addr", o_addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'hF000_FFFC, 1'b0, '0, 1'b0);
        step();
        chk("wrap_addr", o_addr, 32'h0);
        chk("wrap_pc", o_pc, 32'hFFFF_FFFC);

`ifdef INSTR_FETCH_PERF_CNT_EN
        // Three fetches with 3-cycle latency: two stall cycles each.
        do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            step();
            step();
            drive(1'b1, 32'h1234_0000 + k, 1'b0, '0, 1'b1);
            step();
        end
        chk("perf_stall", o_stall_cycles, 32'd6);
        chk("perf_fetch", o_fetch_count, 32'd3);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            i_areset      = ($urandom_range(0, 499) == 0);
            i_instr_valid = m_req && ($urandom_range(0, 2) != 0);
            i_instruction = $urandom;
            i_redirect    = ($urandom_range(0, 15) == 0);
            i_redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                        : $urandom;
            if (((c / 256) % 2) == 1) i_ready = ($urandom_range(0, 3) == 0);
            else                      i_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
